// File: rtl/lcd_bus_arbiter.sv
// Round-robin arbiter sharing one KS0108-style LCD write bus between two requesters,
// with LCD reset sequencing and setup/E-pulse/hold timing. Optional grant lock: LCD_ARB_LOCK_EN.
module lcd_bus_arbiter #(
    parameter int RST_CYC   = 16,
    parameter int SETUP_CYC = 2,
    parameter int EN_CYC    = 2,
    parameter int HOLD_CYC  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic       req0_di,
    input  logic [1:0] req0_cs,
    input  logic [7:0] req0_data,
    input  logic       req0_lock,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic       req1_di,
    input  logic [1:0] req1_cs,
    input  logic [7:0] req1_data,
    input  logic       req1_lock,
    output logic [7:0] lcd_d,
    output logic       lcd_di,
    output logic       lcd_wr,
    output logic       lcd_cs1,
    output logic       lcd_cs2,
    output logic       lcd_en,
    output logic       lcd_rst,
    output logic [1:0] grant,
    output logic       busy
);

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    localparam logic [7:0] RST_LOAD   = 8'(RST_CYC - 1);
    localparam logic [7:0] SETUP_LOAD = 8'(SETUP_CYC - 1);
    localparam logic [7:0] EN_LOAD    = 8'(EN_CYC - 1);
    localparam logic [7:0] HOLD_LOAD  = 8'(HOLD_CYC - 1);

    state_t     state, state_next;
    logic [7:0] cnt, cnt_next;
    logic [1:0] valid;
    logic [1:0] eligible;
    logic [1:0] win;

    assign valid = {req1_valid, req0_valid};

`ifdef LCD_ARB_LOCK_EN
    logic       locked;
    logic       owner;
    logic [1:0] lock;
    logic       lock_hold;

    assign lock = {req1_lock, req0_lock};
    // The lock survives IDLE while its owner still asks (valid) or still claims it (lock).
    assign lock_hold = locked && (valid[owner] || lock[owner]);
    assign eligible  = lock_hold ? (valid & (owner ? 2'b10 : 2'b01)) : valid;
`else
    logic unused_lock;

    assign unused_lock = req0_lock ^ req1_lock;
    assign eligible    = valid;
`endif

    // Tie goes to whoever was not granted last; grant==00 after reset favours req0.
    always_comb begin
        win = 2'b00;
        if (state == IDLE) begin
            case (eligible)
                2'b01:   win = 2'b01;
                2'b10:   win = 2'b10;
                2'b11:   win = (grant == 2'b01) ? 2'b10 : 2'b01;
                default: win = 2'b00;
            endcase
        end
    end

    assign req0_ready = win[0];
    assign req1_ready = win[1];
    assign busy       = (state != IDLE);
    assign lcd_en     = (state == STROBE);
    assign lcd_rst    = (state != INIT);
    assign lcd_wr     = 1'b0;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            INIT: begin
                if (cnt == 8'd0) state_next = IDLE;
                else             cnt_next   = cnt - 8'd1;
            end
            IDLE: begin
                if (win != 2'b00) begin
                    state_next = SETUP;
                    cnt_next   = SETUP_LOAD;
                end
            end
            SETUP: begin
                if (cnt == 8'd0) begin
                    state_next = STROBE;
                    cnt_next   = EN_LOAD;
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end
            STROBE: begin
                if (cnt == 8'd0) begin
                    state_next = HOLD;
                    cnt_next   = HOLD_LOAD;
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end
            HOLD: begin
                if (cnt == 8'd0) state_next = IDLE;
                else             cnt_next   = cnt - 8'd1;
            end
            default: begin
                state_next = INIT;
                cnt_next   = RST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= INIT;
            cnt     <= RST_LOAD;
            lcd_d   <= 8'h00;
            lcd_di  <= 1'b0;
            lcd_cs1 <= 1'b0;
            lcd_cs2 <= 1'b0;
            grant   <= 2'b00;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (win != 2'b00) begin
                lcd_d   <= win[1] ? req1_data : req0_data;
                lcd_di  <= win[1] ? req1_di : req0_di;
                lcd_cs1 <= win[1] ? req1_cs[0] : req0_cs[0];
                lcd_cs2 <= win[1] ? req1_cs[1] : req0_cs[1];
                grant   <= win;
            end
        end
    end

`ifdef LCD_ARB_LOCK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            locked <= 1'b0;
            owner  <= 1'b0;
        end else if (win != 2'b00) begin
            locked <= win[1] ? req1_lock : req0_lock;
            owner  <= win[1];
        end else if (state == IDLE && locked && !lock_hold) begin
            locked <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Bench for lcd_bus_arbiter: directed scenarios plus randomized traffic, checked every cycle
// against a timeline model (bus free time, strobe window, round-robin/lock winner rules).
module tb_lcd_bus_arbiter;

    localparam int RST_CYC   = 16;
    localparam int SETUP_CYC = 2;
    localparam int EN_CYC    = 2;
    localparam int HOLD_CYC  = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0_valid = 1'b0, req0_di = 1'b0, req0_lock = 1'b0;
    logic [1:0] req0_cs = 2'b00;
    logic [7:0] req0_data = 8'h00;
    logic       req1_valid = 1'b0, req1_di = 1'b0, req1_lock = 1'b0;
    logic [1:0] req1_cs = 2'b00;
    logic [7:0] req1_data = 8'h00;
    logic       req0_ready, req1_ready;
    logic [7:0] lcd_d;
    logic       lcd_di, lcd_wr, lcd_cs1, lcd_cs2, lcd_en, lcd_rst, busy;
    logic [1:0] grant;

    lcd_bus_arbiter #(
        .RST_CYC(RST_CYC), .SETUP_CYC(SETUP_CYC), .EN_CYC(EN_CYC), .HOLD_CYC(HOLD_CYC)
    ) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_di(req0_di),
        .req0_cs(req0_cs), .req0_data(req0_data), .req0_lock(req0_lock),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_di(req1_di),
        .req1_cs(req1_cs), .req1_data(req1_data), .req1_lock(req1_lock),
        .lcd_d(lcd_d), .lcd_di(lcd_di), .lcd_wr(lcd_wr), .lcd_cs1(lcd_cs1),
        .lcd_cs2(lcd_cs2), .lcd_en(lcd_en), .lcd_rst(lcd_rst), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Pending writes per requester: {lock, di, cs[1:0], data[7:0]}
    logic [11:0] q0[$];
    logic [11:0] q1[$];
    logic [1:0]  mask = 2'b11;

    // Reference model state (interval n = n-th clock period after reset release)
    int         n;
    int         free_at;
    int         en_at;
    logic [7:0] m_d;
    logic       m_di, m_cs1, m_cs2;
    logic [1:0] m_grant;
    logic       m_locked;
    int         m_own;
    logic       pend;
    logic [11:0] pend_item;
    logic [1:0] pend_grant;
    logic       log_en = 1'b0;
    logic       log_next = 1'b0;
    logic [1:0] obs_q[$];
    logic [1:0] exp_q[$];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_init();
        n = 0;
        free_at = RST_CYC;
        en_at = -100;
        m_d = 8'h00; m_di = 1'b0; m_cs1 = 1'b0; m_cs2 = 1'b0;
        m_grant = 2'b00;
        m_locked = 1'b0;
        m_own = 0;
        pend = 1'b0;
        log_next = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q0.delete();
        q1.delete();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_init();
    endtask

    // One clock period: drive inputs, check all outputs against the model, advance.
    task automatic step();
        logic [11:0] it0, it1, itw;
        logic [1:0]  v, lk, elig, exp_rdy;
        logic        m_busy, m_en;
        int          w;
        it0 = (q0.size() > 0) ? q0[0] : 12'h000;
        it1 = (q1.size() > 0) ? q1[0] : 12'h000;
        v   = {mask[1] && (q1.size() > 0), mask[0] && (q0.size() > 0)};
        lk  = {it1[11], it0[11]};
        req0_valid = v[0]; req0_lock = it0[11]; req0_di = it0[10]; req0_cs = it0[9:8]; req0_data = it0[7:0];
        req1_valid = v[1]; req1_lock = it1[11]; req1_di = it1[10]; req1_cs = it1[9:8]; req1_data = it1[7:0];
        #1;
        if (log_next) begin
            obs_q.push_back(grant);
            log_next = 1'b0;
        end
        m_busy = (n < free_at);
        m_en   = (n >= en_at) && (n < en_at + EN_CYC);
        elig   = m_busy ? 2'b00 : v;
`ifdef LCD_ARB_LOCK_EN
        if (!m_busy && m_locked) begin
            if (v[m_own] || lk[m_own]) elig = v & (m_own == 1 ? 2'b10 : 2'b01);
            else m_locked = 1'b0;
        end
`endif
        w = -1;
        if (elig == 2'b01) w = 0;
        else if (elig == 2'b10) w = 1;
        else if (elig == 2'b11) w = (m_grant == 2'b01) ? 1 : 0;
        exp_rdy = (w == 0) ? 2'b01 : (w == 1) ? 2'b10 : 2'b00;
        chk("ready0", 16'(req0_ready), 16'(exp_rdy[0]));
        chk("ready1", 16'(req1_ready), 16'(exp_rdy[1]));
        chk("busy", 16'(busy), 16'(m_busy));
        chk("lcd_en", 16'(lcd_en), 16'(m_en));
        chk("lcd_rst", 16'(lcd_rst), 16'(n >= RST_CYC));
        chk("lcd_wr", 16'(lcd_wr), 16'h0);
        chk("lcd_d", 16'(lcd_d), 16'(m_d));
        chk("lcd_di", 16'(lcd_di), 16'(m_di));
        chk("lcd_cs", 16'({lcd_cs2, lcd_cs1}), 16'({m_cs2, m_cs1}));
        chk("grant", 16'(grant), 16'(m_grant));
        if (w >= 0) begin
            itw = (w == 1) ? it1 : it0;
            pend = 1'b1;
            pend_item = itw;
            pend_grant = exp_rdy;
            free_at = n + 1 + SETUP_CYC + EN_CYC + HOLD_CYC;
            en_at = n + 1 + SETUP_CYC;
            m_locked = lk[w];
            m_own = w;
            if (w == 1) void'(q1.pop_front());
            else void'(q0.pop_front());
        end
        @(posedge clk);
        #1;
        n++;
        if (pend) begin
            m_d = pend_item[7:0];
            m_di = pend_item[10];
            m_cs1 = pend_item[8];
            m_cs2 = pend_item[9];
            m_grant = pend_grant;
            pend = 1'b0;
            log_next = log_en;
        end
    endtask

    task automatic run_drain(input string tag);
        int k;
        k = 0;
        while ((q0.size() > 0 || q1.size() > 0 || n < free_at || log_next) && k < 2000) begin
            step();
            k++;
        end
        chk(tag, 16'(k < 2000), 16'h1);
    endtask

    task automatic cmp_log(input string tag);
        chk(tag, 16'(obs_q.size()), 16'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk(tag, 16'(obs_q[i]), 16'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        model_init();
        do_reset();

        // req0 requests during INIT: must wait until IDLE; then the A5 write
        q0.push_back({1'b0, 1'b1, 2'b01, 8'hA5});
        run_drain("init_then_a5");
        chk("a5_data", 16'(lcd_d), 16'h00A5);
        chk("a5_cs1", 16'(lcd_cs1), 16'h1);

        // Both valid continuously right after reset: 01,10,01,10
        do_reset();
        log_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            q0.push_back({1'b0, 1'b0, 2'b10, 8'(8'h10 + i)});
            q1.push_back({1'b0, 1'b1, 2'b11, 8'(8'h20 + i)});
        end
        exp_q = '{2'b01, 2'b10, 2'b01, 2'b10};
        run_drain("alt_drain");
        cmp_log("alt_order");

        // Lock stimulus: req1 lock=1,1,0 with req0 valid, after a req0 write
        log_en = 1'b0;
        q0.push_back({1'b0, 1'b0, 2'b01, 8'h01});
        run_drain("pre_lock");
        log_en = 1'b1;
        q1.push_back({1'b1, 1'b0, 2'b01, 8'hB0});
        q1.push_back({1'b1, 1'b1, 2'b01, 8'hB1});
        q1.push_back({1'b0, 1'b1, 2'b01, 8'hB2});
        q0.push_back({1'b0, 1'b1, 2'b10, 8'hC0});
        q0.push_back({1'b0, 1'b1, 2'b10, 8'hC1});
`ifdef LCD_ARB_LOCK_EN
        exp_q = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
`else
        exp_q = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`endif
        run_drain("lock_drain");
        cmp_log("lock_order");
        log_en = 1'b0;

        // Randomized traffic with gaps and legal valid drops
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0 && q0.size() < 3)
                q0.push_back(12'($urandom_range(0, 4095)));
            if ($urandom_range(0, 3) == 0 && q1.size() < 3)
                q1.push_back(12'($urandom_range(0, 4095)));
            if ($urandom_range(0, 5) == 0) mask[0] = ~mask[0];
            if ($urandom_range(0, 5) == 0) mask[1] = ~mask[1];
            step();
        end
        mask = 2'b11;
        run_drain("rand_drain");

        // Reset asserted while lcd_en=1: immediate return to reset values, write dropped
        q0.push_back({1'b0, 1'b1, 2'b11, 8'h5A});
        begin
            int k;
            k = 0;
            step();
            while (n != en_at && k < 100) begin
                step();
                k++;
            end
            chk("reach_strobe", 16'(k < 100), 16'h1);
        end
        #1;
        chk("en_before_rst", 16'(lcd_en), 16'h1);
        reset = 1'b1;
        #1;
        chk("rst_lcd_en", 16'(lcd_en), 16'h0);
        chk("rst_lcd_rst", 16'(lcd_rst), 16'h0);
        chk("rst_busy", 16'(busy), 16'h1);
        chk("rst_grant", 16'(grant), 16'h0);
        chk("rst_lcd_d", 16'(lcd_d), 16'h0);
        chk("rst_ready", 16'({req1_ready, req0_ready}), 16'h0);
        do_reset();
        repeat (RST_CYC + 12) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
